cpu_program_loader: RTL

- Back-door loader that fills the single-cycle CPU's instruction and data memories from an 8-bit byte stream, then releases the CPU.
- Sits between an external byte source (host link or bench driver) and the CPU's instruction-memory word write port and data-memory byte write port.
- Drives the CPU start input; start stays low until a complete, valid image has been written.

---
 rtl/cpu_program_loader_if.sv | 35 +++
 rtl/cpu_program_loader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cpu_program_loader_if.sv
// Byte-stream and memory back-door bundle for the program loader.
// The loader takes the slave side; the host or bench drives master.
interface cpu_program_loader_if #(
    parameter int IAW = 8,
    parameter int DAW = 5
);
    logic           byte_valid_i;
    logic [7:0]     byte_data_i;
    logic           byte_ready_o;
    logic           imem_we_o;
    logic [IAW-1:0] imem_addr_o;
    logic [31:0]    imem_data_o;
    logic           dmem_we_o;
    logic [DAW-1:0] dmem_addr_o;
    logic [7:0]     dmem_data_o;
    logic           start_o;
    logic           busy_o;
    logic           error_o;

    modport slave (
        input  byte_valid_i, byte_data_i,
        output byte_ready_o,
        output imem_we_o, imem_addr_o, imem_data_o,
        output dmem_we_o, dmem_addr_o, dmem_data_o,
        output start_o, busy_o, error_o
    );

    modport master (
        output byte_valid_i, byte_data_i,
        input  byte_ready_o,
        input  imem_we_o, imem_addr_o, imem_data_o,
        input  dmem_we_o, dmem_addr_o, dmem_data_o,
        input  start_o, busy_o, error_o
    );
endinterface

// File: rtl/cpu_program_loader.sv
// Loads instruction words and data bytes from a byte stream into the CPU
// memories, then raises start. Image: MAGIC, N, N LE words, M, M bytes.
module cpu_program_loader #(
    parameter int         IMEM_DEPTH = 256,
    parameter int         DMEM_DEPTH = 32,
    parameter logic [7:0] MAGIC      = 8'hA5
) (
    input logic clk_i,
    input logic rst_i,
    cpu_program_loader_if.slave bus
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam logic [7:0] DMAX = 8'(DMEM_DEPTH);

    typedef enum logic [2:0] {
        S_MAGIC,
        S_ICNT,
        S_IWORD,
        S_DCNT,
        S_DBYTE,
        S_DONE,
        S_ERR
    } state_t;

    state_t         state;
    logic [7:0]     n;
    logic [7:0]     m;
    logic [IAW-1:0] widx;
    logic [1:0]     lane;
    logic [23:0]    wbuf;
    logic [DAW-1:0] daddr;
    logic           acc;
    logic [7:0]     din;

    assign bus.byte_ready_o = (state == S_MAGIC) || (state == S_ICNT) ||
                              (state == S_IWORD) || (state == S_DCNT) ||
                              (state == S_DBYTE);
    assign acc = bus.byte_valid_i && bus.byte_ready_o;
    assign din = bus.byte_data_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state           <= S_MAGIC;
            n               <= '0;
            m               <= '0;
            widx            <= '0;
            lane            <= '0;
            wbuf            <= '0;
            daddr           <= '0;
            bus.imem_we_o   <= 1'b0;
            bus.imem_addr_o <= '0;
            bus.imem_data_o <= '0;
            bus.dmem_we_o   <= 1'b0;
            bus.dmem_addr_o <= '0;
            bus.dmem_data_o <= '0;
            bus.start_o     <= 1'b0;
            bus.busy_o      <= 1'b0;
            bus.error_o     <= 1'b0;
        end else begin
            bus.imem_we_o <= 1'b0;
            bus.dmem_we_o <= 1'b0;
            bus.start_o   <= (state == S_DONE);
            bus.error_o   <= (state == S_ERR);
            if (acc) begin
                unique case (state)
                    S_MAGIC: begin
                        if (din == MAGIC) begin
                            state      <= S_ICNT;
                            bus.busy_o <= 1'b1;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                    S_ICNT: begin
                        n     <= din;
                        widx  <= '0;
                        lane  <= '0;
                        state <= (din == 8'd0) ? S_DCNT : S_IWORD;
                    end
                    S_IWORD: begin
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            bus.imem_we_o   <= 1'b1;
                            bus.imem_addr_o <= widx;
                            bus.imem_data_o <= {din, wbuf};
                            widx            <= widx + 1'b1;
                            if (widx == IAW'(n - 8'd1)) state <= S_DCNT;
                        end else begin
                            // byte 0 ends up in the low lane after three shifts
                            wbuf <= {din, wbuf[23:8]};
                        end
                    end
                    S_DCNT: begin
                        m     <= din;
                        daddr <= '0;
                        if (din > DMAX) begin
                            state      <= S_ERR;
                            bus.busy_o <= 1'b0;
                        end else if (din == 8'd0) begin
                            state      <= S_DONE;
                            bus.busy_o <= 1'b0;
                        end else begin
                            state <= S_DBYTE;
                        end
                    end
                    S_DBYTE: begin
                        bus.dmem_we_o   <= 1'b1;
                        bus.dmem_addr_o <= daddr;
                        bus.dmem_data_o <= din;
                        daddr           <= daddr + 1'b1;
                        if (8'(daddr) == m - 8'd1) begin
                            state      <= S_DONE;
                            bus.busy_o <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
